// File: rtl/scale_demux_reg.sv
// scale_demux_reg
//   Registered 1-to-2 demultiplexer. Each beat accepted on the input stream
//   is steered by sel_a into a one-entry output register for destination A
//   or B. The two destinations stall independently; a stalled destination
//   never blocks beats headed for the other one. Each destination also
//   counts delivered beats (output handshakes) for bring-up and debug.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_         asynchronous active-low reset
//   in_data      input beat data
//   in_valid     input beat present
//   sel_a        1: route beat to A, 0: route beat to B
//   in_ready     demux accepts the beat this cycle
//   out_a        destination A data (held after drain, qualify with valid)
//   out_a_valid  destination A beat present
//   out_a_ready  destination A consumes beat
//   out_b        destination B data (held after drain, qualify with valid)
//   out_b_valid  destination B beat present
//   out_b_ready  destination B consumes beat
//   cnt_a        beats delivered on A, wraps
//   cnt_b        beats delivered on B, wraps

module scale_demux_reg #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 sel_a,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_a,
  output logic                 out_a_valid,
  input  logic                 out_a_ready,
  output logic [WIDTH-1:0]     out_b,
  output logic                 out_b_valid,
  input  logic                 out_b_ready,
  output logic [CNT_WIDTH-1:0] cnt_a,
  output logic [CNT_WIDTH-1:0] cnt_b
);

  logic room_a;
  logic room_b;
  logic accept;
  logic load_a;
  logic load_b;
  logic drain_a;
  logic drain_b;

  // A register can take a new beat when it is empty or is being drained in
  // the same cycle, which gives one beat per cycle with no bubble.
  assign room_a  = !out_a_valid || out_a_ready;
  assign room_b  = !out_b_valid || out_b_ready;

  // Gated with rst_ so in_ready drops immediately on reset assertion rather
  // than waiting for the registers to clear.
  assign in_ready = rst_ && (sel_a ? room_a : room_b);

  assign accept  = in_valid && in_ready;
  assign load_a  = accept && sel_a;
  assign load_b  = accept && !sel_a;
  assign drain_a = out_a_valid && out_a_ready;
  assign drain_b = out_b_valid && out_b_ready;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      out_a       <= '0;
      out_a_valid <= 1'b0;
      cnt_a       <= '0;
    end else begin
      if (load_a) begin
        out_a       <= in_data;
        out_a_valid <= 1'b1;
      end else if (drain_a) begin
        out_a_valid <= 1'b0;
      end
      if (drain_a) begin
        cnt_a <= cnt_a + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      out_b       <= '0;
      out_b_valid <= 1'b0;
      cnt_b       <= '0;
    end else begin
      if (load_b) begin
        out_b       <= in_data;
        out_b_valid <= 1'b1;
      end else if (drain_b) begin
        out_b_valid <= 1'b0;
      end
      if (drain_b) begin
        cnt_b <= cnt_b + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scale_demux_reg.sv
// tb_scale_demux_reg
//   Bench for scale_demux_reg. Reference model: one queue of undelivered
//   beats per destination plus delivered-beat totals; expected outputs are
//   derived from those queues, never from the DUT.

module tb_scale_demux_reg;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 8;

  logic                 clk;
  logic                 rst_;
  logic [WIDTH-1:0]     in_data;
  logic                 in_valid;
  logic                 sel_a;
  logic                 in_ready;
  logic [WIDTH-1:0]     out_a;
  logic                 out_a_valid;
  logic                 out_a_ready;
  logic [WIDTH-1:0]     out_b;
  logic                 out_b_valid;
  logic                 out_b_ready;
  logic [CNT_WIDTH-1:0] cnt_a;
  logic [CNT_WIDTH-1:0] cnt_b;

  scale_demux_reg #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .sel_a       (sel_a),
    .in_ready    (in_ready),
    .out_a       (out_a),
    .out_a_valid (out_a_valid),
    .out_a_ready (out_a_ready),
    .out_b       (out_b),
    .out_b_valid (out_b_valid),
    .out_b_ready (out_b_ready),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  logic [WIDTH-1:0] q_a[$];
  logic [WIDTH-1:0] q_b[$];
  logic [WIDTH-1:0] last_a;
  logic [WIDTH-1:0] last_b;
  int               tot_a;
  int               tot_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    last_a = '0;
    last_b = '0;
    tot_a  = 0;
    tot_b  = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_va"}, 32'(out_a_valid), 32'(q_a.size() != 0));
    chk({tag, "_vb"}, 32'(out_b_valid), 32'(q_b.size() != 0));
    if (q_a.size() != 0) chk({tag, "_da"}, 32'(out_a), 32'(q_a[0]));
    else                 chk({tag, "_ha"}, 32'(out_a), 32'(last_a));
    if (q_b.size() != 0) chk({tag, "_db"}, 32'(out_b), 32'(q_b[0]));
    else                 chk({tag, "_hb"}, 32'(out_b), 32'(last_b));
    chk({tag, "_ca"}, 32'(cnt_a), 32'(tot_a % (1 << CNT_WIDTH)));
    chk({tag, "_cb"}, 32'(cnt_b), 32'(tot_b % (1 << CNT_WIDTH)));
  endtask

  // One clock cycle. Entered and left at posedge+1.
  task automatic cyc(input string tag, input logic v, input logic s,
                     input logic [WIDTH-1:0] d, input logic ra, input logic rb);
    logic exp_rdy, acc, hs_a, hs_b, stall_a, stall_b;
    logic [WIDTH-1:0] hold_a, hold_b;
    in_valid    = v;
    sel_a       = s;
    in_data     = d;
    out_a_ready = ra;
    out_b_ready = rb;
    #1;
    exp_rdy = s ? (q_a.size() == 0 || ra) : (q_b.size() == 0 || rb);
    chk({tag, "_rdy"}, 32'(in_ready), 32'(exp_rdy));
    hs_a    = (q_a.size() != 0) && ra;
    hs_b    = (q_b.size() != 0) && rb;
    acc     = v && exp_rdy;
    stall_a = (q_a.size() != 0) && !ra;
    stall_b = (q_b.size() != 0) && !rb;
    hold_a  = stall_a ? q_a[0] : '0;
    hold_b  = stall_b ? q_b[0] : '0;
    @(posedge clk);
    #1;
    if (hs_a) begin void'(q_a.pop_front()); tot_a++; end
    if (hs_b) begin void'(q_b.pop_front()); tot_b++; end
    if (acc && s)  begin q_a.push_back(d); last_a = d; end
    if (acc && !s) begin q_b.push_back(d); last_b = d; end
    check_outputs(tag);
    if (stall_a) chk({tag, "_stall_a"}, 32'(out_a), 32'(hold_a));
    if (stall_b) chk({tag, "_stall_b"}, 32'(out_b), 32'(hold_b));
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  initial begin
    rst_        = 1'b0;
    in_valid    = 1'b0;
    sel_a       = 1'b0;
    in_data     = '0;
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b1;
    check_outputs("init");

    // 1. reset mid-stream with A holding 5A
    cyc("r_ld", 1, 1, 8'h5A, 0, 0);
    chk("r_pre_a", 32'(out_a), 32'h5A);
    in_valid    = 1'b1;
    sel_a       = 1'b1;
    out_a_ready = 1'b0;
    #1;
    rst_ = 1'b0;
    #1;
    chk("r_va", 32'(out_a_valid), 32'h0);
    chk("r_da", 32'(out_a), 32'h00);
    chk("r_ca", 32'(cnt_a), 32'h0);
    chk("r_rdy", 32'(in_ready), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    check_outputs("r_post");

    // 2. routing
    cyc("rt1", 1, 1, 8'hFF, 1, 1);
    chk("rt_a", 32'(out_a), 32'hFF);
    cyc("rt2", 1, 0, 8'h0F, 1, 1);
    chk("rt_b", 32'(out_b), 32'h0F);
    cyc("rt3", 0, 0, 8'h00, 1, 1);
    chk("rt_cnt_a", 32'(cnt_a), 32'd1);
    chk("rt_cnt_b", 32'(cnt_b), 32'd1);

    // 3. stall on A, B keeps accepting
    cyc("st1", 1, 1, 8'hAA, 0, 1);
    cyc("st2", 1, 1, 8'h11, 0, 1);
    chk("st_hold", 32'(out_a), 32'hAA);
    cyc("st3", 1, 0, 8'h33, 0, 1);
    chk("st_b", 32'(out_b), 32'h33);
    chk("st_hold2", 32'(out_a), 32'hAA);
    cyc("st4", 0, 0, 8'h00, 1, 1);

    // 4. back-to-back throughput on A
    for (int i = 0; i < 16; i++) begin
      cyc("tp", 1, 1, 8'(i), 1, 1);
      chk("tp_data", 32'(out_a), 32'(i));
    end
    cyc("tp_end", 0, 0, 8'h00, 1, 1);

    // 5. counter wrap on B
    do_reset();
    for (int i = 0; i < 257; i++) cyc("wr", 1, 0, 8'(i), 1, 1);
    cyc("wr_end", 0, 0, 8'h00, 1, 1);
    chk("wr_cnt_b", 32'(cnt_b), 32'd1);
    chk("wr_cnt_a", 32'(cnt_a), 32'd0);

    // 6. random traffic
    for (int i = 0; i < 10000; i++) begin
      cyc("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end
    cyc("rnd_d1", 0, 0, 8'h00, 1, 1);
    cyc("rnd_d2", 0, 0, 8'h00, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
